// File: rtl/iq_symbol_mapper_pkg.sv
// Shared types and level helpers for the I/Q symbol mapper.
// Mode encodings match the two-bit mode_i pins of the chip top.
package iq_mod_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'b00,
    MOD_QPSK  = 2'b01,
    MOD_QAM16 = 2'b10,
    MOD_IDLE  = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EMPTY = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  // Number of data bits consumed by one symbol in the given mode.
  function automatic logic [2:0] bits_per_sym(input mod_e mode);
    logic [2:0] k;
    case (mode)
      MOD_BPSK: k = 3'd1;
      MOD_QPSK: k = 3'd2;
      default:  k = 3'd4;
    endcase
    return k;
  endfunction

  // Full-scale amplitude for a signed sample of the given width.
  function automatic int level_a(input int iq_w);
    return (1 << (iq_w - 1)) - 1;
  endfunction

  // 16-QAM inner level; the outer level is three times this.
  function automatic int level_s(input int iq_w);
    return level_a(iq_w) / 3;
  endfunction

  // Gray-coded 16-QAM amplitude for one axis: 00 -3S, 01 -S, 11 +S, 10 +3S.
  function automatic int qam_level(input logic [1:0] bits, input int iq_w);
    int s;
    int lvl;
    s = level_s(iq_w);
    case (bits)
      2'b00:   lvl = -3 * s;
      2'b01:   lvl = -s;
      2'b11:   lvl = s;
      default: lvl = 3 * s;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/iq_symbol_mapper_fifo.sv
// Small synchronous FIFO for incoming data words.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// The head word is presented combinationally on pop_data while not empty.
module word_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; reset empties the FIFO and discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/iq_symbol_mapper.sv
// BPSK / QPSK / 16-QAM symbol mapper between the data pins and the I/Q pins.
// Words are buffered, sliced MSB first into k-bit symbols, and each symbol is
// held for sps cycles. Decisions are made one cycle ahead of the output
// registers, so strobe, samples and underrun all appear together.
module iq_symbol_mapper #(
  parameter int IQ_W       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SPS_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic [3:0]       data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic [SPS_W-1:0] sps_i,
  output logic [IQ_W-1:0]  i_out,
  output logic [IQ_W-1:0]  q_out,
  output logic             sym_strobe_o,
  output logic             underrun_o
);

  import iq_mod_pkg::*;

  localparam logic [IQ_W-1:0] POS_A   = IQ_W'(level_a(IQ_W));
  localparam logic [IQ_W-1:0] NEG_A   = IQ_W'(-level_a(IQ_W));
  localparam logic [IQ_W-1:0] QAM_L00 = IQ_W'(qam_level(2'b00, IQ_W));
  localparam logic [IQ_W-1:0] QAM_L01 = IQ_W'(qam_level(2'b01, IQ_W));
  localparam logic [IQ_W-1:0] QAM_L11 = IQ_W'(qam_level(2'b11, IQ_W));
  localparam logic [IQ_W-1:0] QAM_L10 = IQ_W'(qam_level(2'b10, IQ_W));

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       fifo_data;

  state_e           state;
  mod_e             cur_mode;
  mod_e             mode_in;
  mod_e             sym_mode;
  logic [3:0]       sreg;
  logic [3:0]       sym_bits;
  logic [2:0]       rem;
  logic [2:0]       k_cur;
  logic [2:0]       k_new;
  logic [SPS_W-1:0] scnt;
  logic [SPS_W-1:0] sps_reg;
  logic [SPS_W-1:0] sps_eff;
  logic             sample_end;
  logic             boundary;
  logic             take;
  logic             load;
  logic             go_idle;
  logic             starve;
  logic             pend_sym;
  logic             pend_zero;
  logic             pend_underrun;
  logic [IQ_W-1:0]  map_i;
  logic [IQ_W-1:0]  map_q;

  word_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mode_in      = mod_e'(mode_i);
  assign sps_eff      = (sps_i == '0) ? SPS_W'(1) : sps_i;
  assign k_cur        = bits_per_sym(cur_mode);
  assign k_new        = bits_per_sym(mode_in);
  assign sample_end   = (scnt >= sps_reg - SPS_W'(1));
  assign boundary     = sample_end || (state == ST_EMPTY);
  assign data_ready_o = !fifo_full;
  assign fifo_push    = data_valid_i && !fifo_full;
  assign fifo_pop     = load;

  // Boundary decision: finish the current word first, then fetch a new one,
  // otherwise fall silent (idle mode) or report starvation.
  always_comb begin
    take    = 1'b0;
    load    = 1'b0;
    go_idle = 1'b0;
    starve  = 1'b0;
    if (boundary) begin
      if (rem >= k_cur) begin
        take = 1'b1;
      end else if (!fifo_empty && (mode_in != MOD_IDLE)) begin
        load = 1'b1;
      end else if (mode_in == MOD_IDLE) begin
        go_idle = 1'b1;
      end else begin
        starve = 1'b1;
      end
    end
  end

  // Symbol sequencer: bit register, sample counter and state, producing
  // one-cycle requests for the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_EMPTY;
      cur_mode      <= MOD_BPSK;
      sym_mode      <= MOD_BPSK;
      sreg          <= '0;
      sym_bits      <= '0;
      rem           <= '0;
      scnt          <= '0;
      sps_reg       <= SPS_W'(1);
      pend_sym      <= 1'b0;
      pend_zero     <= 1'b0;
      pend_underrun <= 1'b0;
    end else begin
      pend_sym      <= 1'b0;
      pend_zero     <= 1'b0;
      pend_underrun <= 1'b0;
      if (boundary) begin
        sps_reg <= sps_eff;
      end
      if (take) begin
        sym_bits <= sreg;
        sym_mode <= cur_mode;
        sreg     <= sreg << k_cur;
        rem      <= rem - k_cur;
        scnt     <= '0;
        state    <= ST_RUN;
        pend_sym <= 1'b1;
      end else if (load) begin
        sym_bits <= fifo_data;
        sym_mode <= mode_in;
        cur_mode <= mode_in;
        sreg     <= fifo_data << k_new;
        rem      <= 3'd4 - k_new;
        scnt     <= '0;
        state    <= ST_RUN;
        pend_sym <= 1'b1;
      end else if (go_idle || starve) begin
        state         <= go_idle ? ST_IDLE : ST_EMPTY;
        pend_zero     <= 1'b1;
        pend_underrun <= starve && sample_end;
        scnt          <= sample_end ? '0 : scnt + SPS_W'(1);
      end else begin
        scnt <= scnt + SPS_W'(1);
      end
    end
  end

  // Gray-coded 16-QAM amplitude lookup for one axis.
  function automatic logic [IQ_W-1:0] qam_map(input logic [1:0] bits);
    logic [IQ_W-1:0] v;
    case (bits)
      2'b00:   v = QAM_L00;
      2'b01:   v = QAM_L01;
      2'b11:   v = QAM_L11;
      default: v = QAM_L10;
    endcase
    return v;
  endfunction

  // Constellation mapping of the pending symbol; bits are left-aligned.
  always_comb begin
    map_i = '0;
    map_q = '0;
    case (sym_mode)
      MOD_BPSK: begin
        map_i = sym_bits[3] ? NEG_A : POS_A;
      end
      MOD_QPSK: begin
        map_i = sym_bits[3] ? NEG_A : POS_A;
        map_q = sym_bits[2] ? NEG_A : POS_A;
      end
      MOD_QAM16: begin
        map_i = qam_map(sym_bits[3:2]);
        map_q = qam_map(sym_bits[1:0]);
      end
      default: begin
        map_i = '0;
        map_q = '0;
      end
    endcase
  end

  // Output registers: load a new symbol, force silence, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out        <= '0;
      q_out        <= '0;
      sym_strobe_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      sym_strobe_o <= pend_sym;
      underrun_o   <= pend_underrun;
      if (pend_sym) begin
        i_out <= map_i;
        q_out <= map_q;
      end else if (pend_zero) begin
        i_out <= '0;
        q_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Directed bench for iq_symbol_mapper with IQ_W = 4 (A = 7, S = 2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iq_symbol_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic [3:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [3:0] sps_i;
  logic [3:0] i_out;
  logic [3:0] q_out;
  logic       sym_strobe_o;
  logic       underrun_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  iq_symbol_mapper #(
    .IQ_W       (4),
    .FIFO_DEPTH (4),
    .SPS_W      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .sps_i        (sps_i),
    .i_out        (i_out),
    .q_out        (q_out),
    .sym_strobe_o (sym_strobe_o),
    .underrun_o   (underrun_o)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic check_val(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  task automatic check_iq(input string tag, input int exp_i, input int exp_q, input logic exp_strobe);
    check_val({tag, ".i"}, i_out, 4'(exp_i));
    check_val({tag, ".q"}, q_out, 4'(exp_q));
    check_val({tag, ".strobe"}, {3'b000, sym_strobe_o}, {3'b000, exp_strobe});
  endtask

  task automatic check_flag(input string tag, input logic observed, input logic expected);
    check_val(tag, {3'b000, observed}, {3'b000, expected});
  endtask

  // Directed sequence of scenarios, each starting from the EMPTY state.
  initial begin
    rst_n        = 1'b0;
    mode_i       = 2'b00;
    sps_i        = 4'd1;
    data_i       = 4'b0000;
    data_valid_i = 1'b0;

    $display("[TB] reset values");
    step(3);
    check_iq("reset", 0, 0, 1'b0);
    check_flag("reset.underrun", underrun_o, 1'b0);
    check_flag("reset.ready", data_ready_o, 1'b1);
    rst_n = 1'b1;
    step(3);
    check_flag("nodata.strobe", sym_strobe_o, 1'b0);

    $display("[TB] BPSK sps=1 word 1010");
    data_i = 4'b1010; data_valid_i = 1'b1;
    step(1); data_valid_i = 1'b0; base = cyc;
    go_to(base + 2); check_iq("bpsk.s0", -7, 0, 1'b1);
    go_to(base + 3); check_iq("bpsk.s1",  7, 0, 1'b1);
    go_to(base + 4); check_iq("bpsk.s2", -7, 0, 1'b1);
    go_to(base + 5); check_iq("bpsk.s3",  7, 0, 1'b1);
    go_to(base + 6); check_iq("bpsk.end", 0, 0, 1'b0);
    check_flag("bpsk.underrun", underrun_o, 1'b1);

    $display("[TB] QPSK sps=3 word 0110");
    mode_i = 2'b01; sps_i = 4'd3;
    data_i = 4'b0110; data_valid_i = 1'b1;
    step(1); data_valid_i = 1'b0; base = cyc;
    go_to(base + 2); check_iq("qpsk.s0a",  7, -7, 1'b1);
    check_flag("qpsk.s0a.underrun", underrun_o, 1'b0);
    go_to(base + 3); check_iq("qpsk.s0b",  7, -7, 1'b0);
    go_to(base + 4); check_iq("qpsk.s0c",  7, -7, 1'b0);
    go_to(base + 5); check_iq("qpsk.s1a", -7,  7, 1'b1);
    go_to(base + 7); check_iq("qpsk.s1c", -7,  7, 1'b0);
    go_to(base + 8); check_iq("qpsk.end",  0,  0, 1'b0);
    check_flag("qpsk.underrun", underrun_o, 1'b1);

    $display("[TB] 16-QAM sps=2 words 1001 0011");
    mode_i = 2'b10; sps_i = 4'd2;
    data_i = 4'b1001; data_valid_i = 1'b1;
    step(1); base = cyc;
    data_i = 4'b0011;
    step(1); data_valid_i = 1'b0;
    go_to(base + 2); check_iq("qam.w0a",  6, -2, 1'b1);
    go_to(base + 3); check_iq("qam.w0b",  6, -2, 1'b0);
    go_to(base + 4); check_iq("qam.w1a", -6,  2, 1'b1);
    go_to(base + 5); check_iq("qam.w1b", -6,  2, 1'b0);
    go_to(base + 6); check_iq("qam.end",  0,  0, 1'b0);
    check_flag("qam.underrun", underrun_o, 1'b1);

    $display("[TB] mode change mid-word");
    mode_i = 2'b00; sps_i = 4'd1;
    data_i = 4'b1100; data_valid_i = 1'b1;
    step(1); base = cyc;
    data_i = 4'b0000;
    step(1); data_valid_i = 1'b0;
    go_to(base + 2); check_iq("mchg.b0", -7, 0, 1'b1);
    mode_i = 2'b01;
    go_to(base + 3); check_iq("mchg.b1", -7, 0, 1'b1);
    go_to(base + 4); check_iq("mchg.b2",  7, 0, 1'b1);
    go_to(base + 5); check_iq("mchg.b3",  7, 0, 1'b1);
    go_to(base + 6); check_iq("mchg.q0",  7, 7, 1'b1);
    go_to(base + 7); check_iq("mchg.q1",  7, 7, 1'b1);
    go_to(base + 8); check_iq("mchg.end", 0, 0, 1'b0);
    check_flag("mchg.underrun", underrun_o, 1'b1);

    $display("[TB] back-pressure 16-QAM sps=15, six words");
    mode_i = 2'b10; sps_i = 4'd15;
    data_i = 4'b1001; data_valid_i = 1'b1;
    step(1); base = cyc;
    data_i = 4'b0011;
    step(1);
    data_i = 4'b1111;
    step(1); check_iq("bp.w0", 6, -2, 1'b1);
    data_i = 4'b0000;
    step(1); check_flag("bp.ready_w4", data_ready_o, 1'b1);
    data_i = 4'b1010;
    step(1); check_flag("bp.ready_full", data_ready_o, 1'b0);
    data_i = 4'b0101;
    go_to(base + 15); check_flag("bp.ready_still_full", data_ready_o, 1'b0);
    check_iq("bp.w0_hold", 6, -2, 1'b0);
    go_to(base + 16); check_flag("bp.ready_after_pop", data_ready_o, 1'b1);
    check_iq("bp.w0_last", 6, -2, 1'b0);
    go_to(base + 17); data_valid_i = 1'b0;
    check_iq("bp.w1", -6,  2, 1'b1);
    go_to(base + 32); check_iq("bp.w2",  2,  2, 1'b1);
    go_to(base + 47); check_iq("bp.w3", -6, -6, 1'b1);
    go_to(base + 62); check_iq("bp.w4",  6,  6, 1'b1);
    go_to(base + 77); check_iq("bp.w5", -2, -2, 1'b1);
    go_to(base + 91); check_iq("bp.w5_last", -2, -2, 1'b0);
    go_to(base + 92); check_iq("bp.end", 0, 0, 1'b0);
    check_flag("bp.underrun", underrun_o, 1'b1);

    $display("[TB] asynchronous reset mid-run");
    mode_i = 2'b01; sps_i = 4'd4;
    data_i = 4'b1111; data_valid_i = 1'b1;
    step(1); base = cyc;
    go_to(base + 3); check_flag("rst.ready_before", data_ready_o, 1'b1);
    go_to(base + 4); check_flag("rst.ready_full", data_ready_o, 1'b0);
    data_valid_i = 1'b0;
    go_to(base + 5); check_iq("rst.running", -7, -7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_iq("rst.async", 0, 0, 1'b0);
    check_flag("rst.async_ready", data_ready_o, 1'b1);
    check_flag("rst.async_underrun", underrun_o, 1'b0);
    step(1);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step(1);
      check_iq("rst.after", 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
